// File: rtl/axi_master_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_master_bridge_if : AXI3-style 64-bit bus between the bridge and a slave
// Revision: 1.0
// ---------------------------------------------------------------------------
interface axi_master_bridge_if;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface
`default_nettype wire

// File: rtl/axi_master_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_master_bridge : single-outstanding CPU request to AXI master bridge.
// Optional slave timeout enabled by defining AXI_MASTER_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_master_bridge #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  wire logic        aclk,
   input  wire logic        areset,
   input  wire logic        req_valid,
   output logic             req_ready,
   input  wire logic        req_wen,
   input  wire logic [31:0] req_addr,
   input  wire logic [63:0] req_wdata,
   input  wire logic [7:0]  req_wstrb,
   input  wire logic [7:0]  req_len,
   output logic             resp_valid,
   output logic [63:0]      resp_rdata,
   output logic             resp_last,
   output logic             resp_err,
   axi_master_bridge_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WRITE = 3'd3,
      S_WRESP = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [63:0] r_wdata;
   logic [7:0]  r_wstrb;
   logic [7:0]  r_beat;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;

   // IDs and the low response bits carry no information for a single-outstanding master
   logic w_unused;
   assign w_unused = ^{bus.rid, bus.bid, bus.rresp[0], bus.bresp[0]};

   assign bus.araddr  = r_addr;
   assign bus.arid    = AXI_ID;
   assign bus.arlen   = r_len;
   assign bus.arsize  = 3'b011;
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'b0000;
   assign bus.arprot  = 3'b000;
   assign bus.arvalid = r_arvalid;
   assign bus.rready  = r_rready;
   assign bus.awid    = AXI_ID;
   assign bus.awaddr  = r_addr;
   assign bus.awlen   = 8'd0;
   assign bus.awsize  = 3'b011;
   assign bus.awburst = 2'b01;
   assign bus.awlock  = 2'b00;
   assign bus.awcache = 4'b0000;
   assign bus.awprot  = 3'b000;
   assign bus.awvalid = r_awvalid;
   assign bus.wid     = AXI_ID;
   assign bus.wdata   = r_wdata;
   assign bus.wstrb   = r_wstrb;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = r_wvalid;
   assign bus.bready  = r_bready;

`ifdef AXI_MASTER_TIMEOUT_EN
   logic [9:0] r_timer;
   logic       w_hs;
   assign w_hs = (r_arvalid & bus.arready) | (r_rready  & bus.rvalid) |
                 (r_awvalid & bus.awready) | (r_wvalid  & bus.wready) |
                 (r_bready  & bus.bvalid);
`endif

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state    <= S_IDLE;
         req_ready  <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         resp_valid <= 1'b0;
         resp_last  <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 64'd0;
         r_addr     <= 32'd0;
         r_len      <= 8'd0;
         r_wdata    <= 64'd0;
         r_wstrb    <= 8'd0;
         r_beat     <= 8'd0;
`ifdef AXI_MASTER_TIMEOUT_EN
         r_timer    <= 10'd0;
`endif
      end else begin
         resp_valid <= 1'b0;
         resp_last  <= 1'b0;
         resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  r_wstrb   <= req_wstrb;
                  if (req_wen) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= S_WRITE;
                  end else begin
                     r_len     <= req_len;
                     r_arvalid <= 1'b1;
                     r_state   <= S_RADDR;
                  end
               end
            end
            S_RADDR: begin
               if (bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_beat    <= 8'd0;
                  r_state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (bus.rvalid) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= bus.rdata;
                  resp_err   <= bus.rresp[1];
                  r_beat     <= r_beat + 8'd1;
                  // Comparing the pre-increment count avoids overflow at arlen=255
                  if (bus.rlast || (r_beat == r_len)) begin
                     resp_last <= 1'b1;
                     r_rready  <= 1'b0;
                     req_ready <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_WRITE: begin
               if (bus.awready) r_awvalid <= 1'b0;
               if (bus.wready)  r_wvalid  <= 1'b0;
               if ((!r_awvalid || bus.awready) && (!r_wvalid || bus.wready)) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (bus.bvalid) begin
                  resp_valid <= 1'b1;
                  resp_last  <= 1'b1;
                  resp_err   <= bus.bresp[1];
                  resp_rdata <= 64'd0;
                  r_bready   <= 1'b0;
                  req_ready  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef AXI_MASTER_TIMEOUT_EN
         if (r_state == S_IDLE) begin
            r_timer <= 10'd0;
         end else if (w_hs) begin
            r_timer <= 10'd0;
         end else if (r_timer == 10'h3FF) begin
            r_timer    <= 10'd0;
            r_state    <= S_IDLE;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_last  <= 1'b1;
            req_ready  <= 1'b1;
         end else begin
            r_timer <= r_timer + 10'd1;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_master_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_master_bridge : directed self-checking bench for axi_master_bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_axi_master_bridge;
   logic        aclk = 1'b0;
   logic        areset;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic [7:0]  req_len;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_last;
   logic        resp_err;

   int tests = 0;
   int fails = 0;

   axi_master_bridge_if bus ();

   axi_master_bridge #(.AXI_ID(4'd0)) dut (
      .aclk       (aclk),
      .areset     (areset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .req_len    (req_len),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_last  (resp_last),
      .resp_err   (resp_err),
      .bus        (bus)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                        input logic [63:0] wdata, input logic [7:0] wstrb);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_len   = len;
      req_wdata = wdata;
      req_wstrb = wstrb;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      logic [63:0] pat [4];
      int n;
      pat[0] = 64'hA0A0_0000_0000_0001;
      pat[1] = 64'hB1B1_0000_0000_0002;
      pat[2] = 64'hC2C2_0000_0000_0003;
      pat[3] = 64'hD3D3_0000_0000_0004;

      areset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; req_len = '0;
      bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = '0; bus.rresp = 2'b00;
      bus.rlast = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
      bus.bid = 4'd0; bus.bresp = 2'b00; bus.bvalid = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_arvalid", bus.arvalid, 0);
      check("rst_awvalid", bus.awvalid, 0);
      check("rst_wvalid", bus.wvalid, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_rready", bus.rready, 0);
      check("rst_bready", bus.bready, 0);
      areset = 1'b0;
      tick();
      check("post_rst_req_ready", req_ready, 1);

      // Single-beat read
      issue(1'b0, 32'h8000_0000, 8'd0, 64'd0, 8'd0);
      check("r1_req_ready", req_ready, 0);
      check("r1_arvalid", bus.arvalid, 1);
      check("r1_araddr", bus.araddr, 32'h8000_0000);
      check("r1_arlen", bus.arlen, 0);
      check("r1_arsize", bus.arsize, 3'b011);
      check("r1_arburst", bus.arburst, 2'b01);
      check("r1_arid", bus.arid, 0);
      check("r1_rready_pre", bus.rready, 0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      check("r1_arvalid_drop", bus.arvalid, 0);
      check("r1_rready", bus.rready, 1);
      bus.rvalid = 1'b1; bus.rdata = 64'h1122_3344_5566_7788; bus.rlast = 1'b1; bus.rresp = 2'b00;
      tick();
      bus.rvalid = 1'b0; bus.rlast = 1'b0;
      check("r1_resp_valid", resp_valid, 1);
      check("r1_resp_rdata", resp_rdata, 64'h1122_3344_5566_7788);
      check("r1_resp_last", resp_last, 1);
      check("r1_resp_err", resp_err, 0);
      tick();
      check("r1_resp_once", resp_valid, 0);
      check("r1_req_ready_back", req_ready, 1);

      // Four-beat read, arready stalled 5 cycles, burst ended by the beat counter
      issue(1'b0, 32'h8000_0040, 8'd3, 64'd0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("r4_stall_arvalid", bus.arvalid, 1);
         check("r4_stall_araddr", bus.araddr, 32'h8000_0040);
         check("r4_stall_arlen", bus.arlen, 3);
      end
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      check("r4_arvalid_drop", bus.arvalid, 0);
      for (int i = 0; i < 4; i++) begin
         bus.rvalid = 1'b1; bus.rdata = pat[i]; bus.rlast = 1'b0;
         tick();
         bus.rvalid = 1'b0;
         check("r4_beat_valid", resp_valid, 1);
         check("r4_beat_data", resp_rdata, pat[i]);
         check("r4_beat_last", resp_last, (i == 3) ? 1 : 0);
         tick();
         check("r4_gap_valid", resp_valid, 0);
         if (i == 1) begin
            tick();
            check("r4_gap2_valid", resp_valid, 0);
         end
         check("r4_rready", bus.rready, (i == 3) ? 0 : 1);
      end
      check("r4_req_ready_back", req_ready, 1);

      // Write with wready arriving 3 cycles after awready
      issue(1'b1, 32'h8000_1000, 8'd5, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      check("w1_awvalid", bus.awvalid, 1);
      check("w1_wvalid", bus.wvalid, 1);
      check("w1_awaddr", bus.awaddr, 32'h8000_1000);
      check("w1_awlen", bus.awlen, 0);
      check("w1_wdata", bus.wdata, 64'h0000_0000_DEAD_BEEF);
      check("w1_wstrb", bus.wstrb, 8'h0F);
      check("w1_wlast", bus.wlast, 1);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      check("w1_awvalid_drop", bus.awvalid, 0);
      check("w1_wvalid_hold", bus.wvalid, 1);
      tick();
      tick();
      check("w1_wvalid_hold2", bus.wvalid, 1);
      check("w1_bready_low", bus.bready, 0);
      bus.wready = 1'b1;
      tick();
      bus.wready = 1'b0;
      check("w1_wvalid_drop", bus.wvalid, 0);
      check("w1_bready", bus.bready, 1);
      tick();
      check("w1_no_resp_yet", resp_valid, 0);
      bus.bvalid = 1'b1; bus.bresp = 2'b00;
      tick();
      bus.bvalid = 1'b0;
      check("w1_resp_valid", resp_valid, 1);
      check("w1_resp_last", resp_last, 1);
      check("w1_resp_err", resp_err, 0);
      check("w1_resp_rdata", resp_rdata, 0);
      tick();
      check("w1_resp_once", resp_valid, 0);
      check("w1_req_ready_back", req_ready, 1);

      // Read error beat; rlast on beat 2 ends a 4-beat burst early
      issue(1'b0, 32'h8000_0080, 8'd3, 64'd0, 8'd0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      bus.rvalid = 1'b1; bus.rdata = pat[0]; bus.rresp = 2'b00; bus.rlast = 1'b0;
      tick();
      check("re_b0_valid", resp_valid, 1);
      check("re_b0_err", resp_err, 0);
      check("re_b0_last", resp_last, 0);
      bus.rdata = pat[1]; bus.rresp = 2'b10; bus.rlast = 1'b1;
      tick();
      bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
      check("re_b1_valid", resp_valid, 1);
      check("re_b1_err", resp_err, 1);
      check("re_b1_last", resp_last, 1);
      check("re_b1_data", resp_rdata, pat[1]);
      tick();
      check("re_after_valid", resp_valid, 0);
      check("re_req_ready", req_ready, 1);

      // Write error, both handshakes in the same cycle; stray rvalid ignored
      issue(1'b1, 32'h8000_2000, 8'd0, 64'h55AA_55AA_55AA_55AA, 8'hFF);
      bus.awready = 1'b1; bus.wready = 1'b1; bus.rvalid = 1'b1;
      tick();
      bus.awready = 1'b0; bus.wready = 1'b0;
      check("we_awvalid", bus.awvalid, 0);
      check("we_wvalid", bus.wvalid, 0);
      check("we_rready_low", bus.rready, 0);
      check("we_no_stray", resp_valid, 0);
      bus.rvalid = 1'b0;
      bus.bvalid = 1'b1; bus.bresp = 2'b10;
      tick();
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      check("we_resp_valid", resp_valid, 1);
      check("we_resp_err", resp_err, 1);
      check("we_resp_last", resp_last, 1);

      // Reset in the middle of a read burst
      tick();
      issue(1'b0, 32'h8000_0100, 8'd3, 64'd0, 8'd0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.rvalid = 1'b1; bus.rdata = pat[i];
         tick();
         check("rr_beat_valid", resp_valid, 1);
         check("rr_beat_last", resp_last, 0);
      end
      areset = 1'b1;
      tick();
      check("rr_rst_resp_valid", resp_valid, 0);
      check("rr_rst_rready", bus.rready, 0);
      check("rr_rst_arvalid", bus.arvalid, 0);
      check("rr_rst_req_ready", req_ready, 0);
      areset = 1'b0;
      tick();
      bus.rvalid = 1'b0;
      check("rr_rel_req_ready", req_ready, 1);
      check("rr_rel_resp_valid", resp_valid, 0);
      tick();
      check("rr_rel_resp_valid2", resp_valid, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
      // Slave never answers the address phase
      issue(1'b0, 32'h8000_0200, 8'd0, 64'd0, 8'd0);
      n = 0;
      while (!resp_valid && n < 1100) begin
         tick();
         n++;
      end
      check("to_resp_valid", resp_valid, 1);
      check("to_resp_err", resp_err, 1);
      check("to_resp_last", resp_last, 1);
      check("to_arvalid", bus.arvalid, 0);
      check("to_cycles_in_range", (n >= 1023 && n <= 1026) ? 1 : 0, 1);
      tick();
      check("to_req_ready", req_ready, 1);
      check("to_resp_once", resp_valid, 0);
`else
      n = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
